// File: rtl/dmem_port_arbiter.sv
// Two-port req/done front end for the single-port data memory.
// One access at a time; misaligned or out-of-range addresses never reach the memory.
//
// state  | meaning
// IDLE   | no command latched, waiting for a request
// ACCESS | latched command drives the memory when legal
// RESP   | done/err pulse to the winner; the other port may be latched

module dmem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_WORDS  = 64,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_done,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS * 4);

  state_t              state_q, state_d;
  logic                last_winner_q, last_winner_d;
  logic                cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic                cmd_id_q, cmd_id_d;
  logic                p0_done_q, p0_done_d;
  logic                p0_err_q, p0_err_d;
  logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
  logic                p1_done_q, p1_done_d;
  logic                p1_err_q, p1_err_d;
  logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;

  logic                cmd_legal;
  logic                mem_active;
  logic                cand0, cand1;
  logic                grant_any;
  logic                grant_id;
  logic                load_cmd;

  assign cmd_legal  = (cmd_addr_q[1:0] == 2'b00) && (cmd_addr_q < ADDR_LIMIT);
  assign mem_active = (state_q == ACCESS) && cmd_legal;

  // In RESP the port being answered is masked so it cannot win back-to-back.
  always_comb begin
    cand0 = p0_req;
    cand1 = p1_req;
    if (state_q == RESP) begin
      if (cmd_id_q) cand1 = 1'b0;
      else          cand0 = 1'b0;
    end
    grant_any = cand0 | cand1;
    if (cand0 && cand1) grant_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_winner_q;
    else                grant_id = cand1;
  end

  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    cmd_we_d      = cmd_we_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_wdata_d   = cmd_wdata_q;
    cmd_id_d      = cmd_id_q;
    p0_done_d     = 1'b0;
    p0_err_d      = 1'b0;
    p0_rdata_d    = p0_rdata_q;
    p1_done_d     = 1'b0;
    p1_err_d      = 1'b0;
    p1_rdata_d    = p1_rdata_q;
    load_cmd      = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          load_cmd = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
        // done/err are registered here so they appear during RESP.
        if (cmd_id_q) begin
          p1_done_d = 1'b1;
          p1_err_d  = ~cmd_legal;
          if (!cmd_we_q) p1_rdata_d = cmd_legal ? mem_rdata : '0;
        end else begin
          p0_done_d = 1'b1;
          p0_err_d  = ~cmd_legal;
          if (!cmd_we_q) p0_rdata_d = cmd_legal ? mem_rdata : '0;
        end
      end
      RESP: begin
        if (grant_any) begin
          load_cmd = 1'b1;
          state_d  = ACCESS;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_cmd) begin
      cmd_id_d      = grant_id;
      last_winner_d = grant_id;
      cmd_we_d      = grant_id ? p1_we    : p0_we;
      cmd_addr_d    = grant_id ? p1_addr  : p0_addr;
      cmd_wdata_d   = grant_id ? p1_wdata : p0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_winner_q <= 1'b1;
      cmd_we_q      <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      cmd_id_q      <= 1'b0;
      p0_done_q     <= 1'b0;
      p0_err_q      <= 1'b0;
      p0_rdata_q    <= '0;
      p1_done_q     <= 1'b0;
      p1_err_q      <= 1'b0;
      p1_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      cmd_we_q      <= cmd_we_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wdata_q   <= cmd_wdata_d;
      cmd_id_q      <= cmd_id_d;
      p0_done_q     <= p0_done_d;
      p0_err_q      <= p0_err_d;
      p0_rdata_q    <= p0_rdata_d;
      p1_done_q     <= p1_done_d;
      p1_err_q      <= p1_err_d;
      p1_rdata_q    <= p1_rdata_d;
    end
  end

  assign p0_done   = p0_done_q;
  assign p0_err    = p0_err_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_done   = p1_done_q;
  assign p1_err    = p1_err_q;
  assign p1_rdata  = p1_rdata_q;

  assign mem_write = mem_active & cmd_we_q;
  assign mem_read  = mem_active & ~cmd_we_q;
  assign mem_addr  = mem_active ? cmd_addr_q  : '0;
  assign mem_wdata = mem_active ? cmd_wdata_q : '0;

  assign busy      = (state_q != IDLE);

endmodule
